mpu_store_stream: RTL

MPU_STORE_STREAM -- requirements
Module: mpu_store_stream

---
 rtl/mpu_store_stream.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mpu_store_stream.sv
// Reads a matrix register one LANES-wide slice per request and streams it out as memory beats.
// Register data returns one cycle after the request and passes through a 2-entry fall-through FIFO.
`timescale 1ns/1ps
module mpu_store_stream #(
    parameter int ELEM_W = 32,
    parameter int DIM_W  = 4,
    parameter int LANES  = 2,
    parameter int REG_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    col_major,
    input  logic [REG_W-1:0]        reg_addr_in,
    input  logic [DIM_W-1:0]        m_size_in,
    input  logic [DIM_W-1:0]        n_size_in,
    output logic                    reg_rd_en,
    output logic [REG_W-1:0]        reg_rd_addr,
    output logic [LANES*DIM_W-1:0]  reg_rd_i,
    output logic [LANES*DIM_W-1:0]  reg_rd_j,
    input  logic [LANES*ELEM_W-1:0] reg_rd_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [LANES*ELEM_W-1:0] mem_data,
    output logic [LANES-1:0]        mem_strb,
    output logic                    mem_last,
    output logic [DIM_W-1:0]        mem_m_size,
    output logic [DIM_W-1:0]        mem_n_size,
    output logic                    busy,
    output logic                    done
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | issuing register reads
    // DRAIN  | all reads issued, emptying the beat pipeline
    // FINISH | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

    localparam int CNT_W = 2 * DIM_W;

    state_t state_q, state_d;

    logic                    col_major_q;
    logic [REG_W-1:0]        reg_addr_q;
    logic [DIM_W-1:0]        m_q, n_q;
    logic [CNT_W-1:0]        elem_left_q;
    logic [DIM_W-1:0]        cur_i_q, cur_j_q;
    logic [DIM_W-1:0]        walk_i, walk_j;
    logic [LANES-1:0]        lane_strb;
    logic [31:0]             left_ext;
    logic                    issue, final_rd;

    logic                    rd_pend_q;
    logic [LANES-1:0]        pend_strb_q;
    logic                    pend_last_q;
    logic [LANES*ELEM_W-1:0] rd_data_masked;

    logic [LANES*ELEM_W-1:0] fifo_data_q [2];
    logic [LANES-1:0]        fifo_strb_q [2];
    logic                    fifo_last_q [2];
    logic                    wr_ptr_q, rd_ptr_q;
    logic [1:0]              fifo_cnt_q;

    logic                    use_fifo, pop, fifo_pop, push;
    logic [LANES*ELEM_W-1:0] head_data;
    logic [LANES-1:0]        head_strb;
    logic                    head_last;

    assign left_ext = 32'(elem_left_q);
    assign final_rd = left_ext <= 32'(LANES);
    assign issue    = (state_q == RUN) && ((fifo_cnt_q + {1'b0, rd_pend_q}) < 2'd2);

    // Walk the element sequence lane by lane from the current position.
    always_comb begin
        lane_strb = '0;
        reg_rd_i  = '0;
        reg_rd_j  = '0;
        walk_i    = cur_i_q;
        walk_j    = cur_j_q;
        for (int k = 0; k < LANES; k++) begin
            if (32'(k) < left_ext) begin
                lane_strb[k] = 1'b1;
                if (issue) begin
                    reg_rd_i[k*DIM_W +: DIM_W] = walk_i;
                    reg_rd_j[k*DIM_W +: DIM_W] = walk_j;
                end
                if (col_major_q) begin
                    if (walk_i == m_q - 1'b1) begin
                        walk_i = '0;
                        walk_j = walk_j + 1'b1;
                    end else begin
                        walk_i = walk_i + 1'b1;
                    end
                end else begin
                    if (walk_j == n_q - 1'b1) begin
                        walk_j = '0;
                        walk_i = walk_i + 1'b1;
                    end else begin
                        walk_j = walk_j + 1'b1;
                    end
                end
            end
        end
    end

    // Lanes past the end of the matrix must read back as zero.
    always_comb begin
        rd_data_masked = '0;
        for (int k = 0; k < LANES; k++) begin
            if (pend_strb_q[k]) begin
                rd_data_masked[k*ELEM_W +: ELEM_W] = reg_rd_data[k*ELEM_W +: ELEM_W];
            end
        end
    end

    assign use_fifo  = fifo_cnt_q != 2'd0;
    assign head_data = use_fifo ? fifo_data_q[rd_ptr_q] : rd_data_masked;
    assign head_strb = use_fifo ? fifo_strb_q[rd_ptr_q] : pend_strb_q;
    assign head_last = use_fifo ? fifo_last_q[rd_ptr_q] : pend_last_q;

    assign mem_valid = use_fifo || rd_pend_q;
    assign mem_data  = mem_valid ? head_data : '0;
    assign mem_strb  = mem_valid ? head_strb : '0;
    assign mem_last  = mem_valid && head_last;
    assign pop       = mem_valid && mem_ready;
    assign fifo_pop  = pop && use_fifo;
    assign push      = rd_pend_q && !(pop && !use_fifo);

    assign reg_rd_en   = issue;
    assign reg_rd_addr = reg_addr_q;
    assign mem_m_size  = m_q;
    assign mem_n_size  = n_q;
    assign busy        = state_q != IDLE;
    assign done        = state_q == FINISH;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (m_size_in == '0 || n_size_in == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN:    if (issue && final_rd) state_d = DRAIN;
            DRAIN:  if (pop && head_last) state_d = FINISH;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_major_q <= 1'b0;
            reg_addr_q  <= '0;
            m_q         <= '0;
            n_q         <= '0;
            elem_left_q <= '0;
            cur_i_q     <= '0;
            cur_j_q     <= '0;
            rd_pend_q   <= 1'b0;
            pend_strb_q <= '0;
            pend_last_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start) begin
                col_major_q <= col_major;
                reg_addr_q  <= reg_addr_in;
                m_q         <= m_size_in;
                n_q         <= n_size_in;
                elem_left_q <= CNT_W'(m_size_in) * CNT_W'(n_size_in);
                cur_i_q     <= '0;
                cur_j_q     <= '0;
            end else if (issue) begin
                cur_i_q     <= walk_i;
                cur_j_q     <= walk_j;
                elem_left_q <= final_rd ? '0 : elem_left_q - CNT_W'(LANES);
            end
            rd_pend_q   <= issue;
            pend_strb_q <= lane_strb;
            pend_last_q <= final_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_strb_q[0] <= '0;
            fifo_strb_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            if (push) begin
                fifo_data_q[wr_ptr_q] <= rd_data_masked;
                fifo_strb_q[wr_ptr_q] <= pend_strb_q;
                fifo_last_q[wr_ptr_q] <= pend_last_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (fifo_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: ;
            endcase
        end
    end

endmodule
